morra_scoreboard: RTL and testbench
===================================

Name: morra_scoreboard

Overview:
Downstream consumer of the Morra Cinese game FSMD. Samples the per-clock MANCHE/PARTITA result pair, keeps per-game tallies and lifetime game counters, and queues one record per finished game in a small FIFO with a valid/ready read port for a display or logging stage. Fully synchronous to the game clock.

Parameters:
CNT_W, 4, width of per-game tally counters (saturating)
GAMES_W, 8, width of lifetime game counters (saturating)
FIFO_DEPTH, 4, number of game-result records held; power of 2, >=2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
inizia  in  1  same INIZIA seen by the game; 1 = restart/configure cycle
manche  in  2  game MANCHE: 00 invalid, 01 P1, 10 P2, 11 tie
partita  in  2  game PARTITA: 00 not ended, 01 P1 wins, 10 P2 wins, 11 draw
p1_score  out  CNT_W  manches won by P1, current game
p2_score  out  CNT_W  manches won by P2, current game
ties  out  CNT_W  tied manches, current game
invalids  out  CNT_W  invalid manches, current game
games_p1  out  GAMES_W  lifetime games won by P1
games_p2  out  GAMES_W  lifetime games won by P2
games_draw  out  GAMES_W  lifetime drawn games
game_over  out  1  current game has ended; waiting for inizia
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer accepts head record
res_data  out  2*CNT_W+2  head record: [2*CNT_W+1:2*CNT_W] winner code, [2*CNT_W-1:CNT_W] P1 final score, [CNT_W-1:0] P2 final score
ovf  out  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n=0): every output 0, state IDLE, FIFO empty, ovf 0. Takes effect immediately regardless of clk. Release is synchronous to the next rising edge.
- All outputs registered; an input sampled at edge N is reflected after edge N.
- States: IDLE, PLAYING, ENDED.
- inizia=1, any state: go to PLAYING; clear p1_score/p2_score/ties/invalids; game_over=0. manche/partita ignored that cycle. Aborting an unfinished game pushes no record and changes no lifetime counter.
- IDLE, inizia=0: all inputs ignored.
- PLAYING, inizia=0: increment exactly one tally from manche (00 -> invalids, 01 -> p1_score, 10 -> p2_score, 11 -> ties). Each tally saturates at 2^CNT_W-1.
- PLAYING, inizia=0, partita!=00: the same cycle's manche is tallied first. Then:
  - go to ENDED and set game_over=1;
  - increment games_p1, games_p2 or games_draw per partita, saturating at 2^GAMES_W-1;
  - push record {partita, updated p1_score, updated p2_score}.
- ENDED, inizia=0: manche/partita ignored; tallies and game_over hold.
- FIFO handshake: res_valid = not empty; res_data = head record, stable while res_valid=1 and res_ready=0. A pop occurs on an edge where res_valid=1 and res_ready=1.
- FIFO timing: no bypass; a pushed record is visible one cycle after the ending sample.
- Push while full with no pop: record dropped, ovf set (sticky until reset). Lifetime counters still increment.
- Push while full with a simultaneous pop: both occur, no drop.
- Push and pop in the same cycle otherwise: count unchanged.
- Pointer widths: log2(FIFO_DEPTH), plus one extra bit for full/empty detection; pointers wrap naturally.

Test Plan:
1. rst_n low mid-game, asynchronously between edges -> all outputs 0 before the next edge; after release, a PLAYING manche is ignored until inizia.
2. inizia; then manche 10, 10, 10 (partita 00); then manche 01 with partita 10 -> p1_score=1, p2_score=3, games_p2=1, game_over=1. One cycle later: res_valid=1, res_data=10_0001_0011.
3. After test 2, apply manche 01 with partita 10 for 3 cycles -> no counter changes. Then inizia -> tallies 0, game_over=0, games_p2 still 1.
4. inizia; manche 01, 00, 11; then inizia -> tallies clear, no FIFO push, lifetime counters unchanged.
5. res_ready=0; play 5 complete games ending P1, P2, draw, P1, P1 -> 4 records queued, ovf=1, games_p1=3. Then end a 6th game with res_ready=1 on the ending edge -> no additional drop; head pops in order.
6. CNT_W=2: inizia, then 5 consecutive manche 01 with partita 00 -> p1_score=3 (saturated), other tallies 0.

Source files
------------

// File: rtl/morra_scoreboard.sv
// Scoreboard for the Morra Cinese game: per-game manche tallies, lifetime game counters
// and a small FIFO of finished-game records behind a valid/ready read port.
module morra_scoreboard #(
    parameter int CNT_W      = 4,
    parameter int GAMES_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inizia,
    input  logic [1:0]           manche,
    input  logic [1:0]           partita,
    output logic [CNT_W-1:0]     p1_score,
    output logic [CNT_W-1:0]     p2_score,
    output logic [CNT_W-1:0]     ties,
    output logic [CNT_W-1:0]     invalids,
    output logic [GAMES_W-1:0]   games_p1,
    output logic [GAMES_W-1:0]   games_p2,
    output logic [GAMES_W-1:0]   games_draw,
    output logic                 game_over,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*CNT_W+1:0]   res_data,
    output logic                 ovf
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = 2*CNT_W + 2;

    typedef enum logic [1:0] {IDLE, PLAYING, ENDED} state_t;

    state_t             state;
    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;

    logic [CNT_W-1:0]   nxt_p1, nxt_p2, nxt_ties, nxt_inv;
    logic               ending, empty, full, pop, push_ok;
    logic [REC_W-1:0]   rec;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [GAMES_W-1:0] sat_games(input logic [GAMES_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Tallies including this cycle's manche; the record must carry the updated scores.
    always_comb begin
        nxt_p1   = p1_score;
        nxt_p2   = p2_score;
        nxt_ties = ties;
        nxt_inv  = invalids;
        case (manche)
            2'b00:   nxt_inv  = sat_cnt(invalids);
            2'b01:   nxt_p1   = sat_cnt(p1_score);
            2'b10:   nxt_p2   = sat_cnt(p2_score);
            default: nxt_ties = sat_cnt(ties);
        endcase
    end

    assign ending  = (state == PLAYING) && !inizia && (partita != 2'b00);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && res_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push_ok = ending && (!full || pop);
    assign rec     = {partita, nxt_p1, nxt_p2};

    assign res_valid = !empty;
    assign res_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p1_score   <= '0;
            p2_score   <= '0;
            ties       <= '0;
            invalids   <= '0;
            games_p1   <= '0;
            games_p2   <= '0;
            games_draw <= '0;
            game_over  <= 1'b0;
            ovf        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (inizia) begin
                state     <= PLAYING;
                p1_score  <= '0;
                p2_score  <= '0;
                ties      <= '0;
                invalids  <= '0;
                game_over <= 1'b0;
            end else if (state == PLAYING) begin
                p1_score <= nxt_p1;
                p2_score <= nxt_p2;
                ties     <= nxt_ties;
                invalids <= nxt_inv;
                if (partita != 2'b00) begin
                    state     <= ENDED;
                    game_over <= 1'b1;
                    case (partita)
                        2'b01:   games_p1   <= sat_games(games_p1);
                        2'b10:   games_p2   <= sat_games(games_p2);
                        default: games_draw <= sat_games(games_draw);
                    endcase
                end
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            else if (ending)
                ovf <= 1'b1;
        end
    end

    // Record storage carries no reset; res_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= rec;
    end

endmodule

// File: tb/tb_morra_scoreboard.sv
// Bench for morra_scoreboard: game-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_morra_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inizia = 1'b0;
    logic [1:0]  manche = 2'b00;
    logic [1:0]  partita = 2'b00;
    logic        res_ready = 1'b0;

    logic [3:0]  p1_score, p2_score, ties, invalids;
    logic [7:0]  games_p1, games_p2, games_draw;
    logic        game_over, res_valid, ovf;
    logic [9:0]  res_data;

    logic [1:0]  s_p1, s_p2, s_ties, s_inv;
    logic [7:0]  s_g1, s_g2, s_gd;
    logic        s_over, s_valid, s_ovf;
    logic [5:0]  s_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    morra_scoreboard #(.CNT_W(4), .GAMES_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .inizia(inizia), .manche(manche), .partita(partita),
        .p1_score(p1_score), .p2_score(p2_score), .ties(ties), .invalids(invalids),
        .games_p1(games_p1), .games_p2(games_p2), .games_draw(games_draw),
        .game_over(game_over), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .ovf(ovf)
    );

    morra_scoreboard #(.CNT_W(2), .GAMES_W(8), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .inizia(inizia), .manche(manche), .partita(partita),
        .p1_score(s_p1), .p2_score(s_p2), .ties(s_ties), .invalids(s_inv),
        .games_p1(s_g1), .games_p2(s_g2), .games_draw(s_gd),
        .game_over(s_over), .res_valid(s_valid), .res_ready(res_ready),
        .res_data(s_data), .ovf(s_ovf)
    );

    // Reference model: unbounded counts, saturation applied only when rendering outputs.
    typedef struct { int w; int a; int b; } rec_t;
    int   mode = 0;               // 0 idle, 1 playing, 2 ended
    int   c_p1 = 0, c_p2 = 0, c_tie = 0, c_inv = 0;
    int   n_p1 = 0, n_p2 = 0, n_dr = 0;
    bit   m_over = 0, m_ovf = 0;
    rec_t q[$];

    function automatic logic [31:0] sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] rec_bits(input rec_t r, input int w);
        int mx = (1 << w) - 1;
        return (r.w << (2*w)) | (sat(r.a, mx) << w) | sat(r.b, mx);
    endfunction

    always @(negedge rst_n) begin
        mode = 0; c_p1 = 0; c_p2 = 0; c_tie = 0; c_inv = 0;
        n_p1 = 0; n_p2 = 0; n_dr = 0; m_over = 0; m_ovf = 0;
        q.delete();
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit   do_pop;
            bit   do_push;
            rec_t r;
            do_pop  = (q.size() > 0) && res_ready;
            do_push = 0;
            r = '{w: 0, a: 0, b: 0};
            if (inizia) begin
                mode = 1; c_p1 = 0; c_p2 = 0; c_tie = 0; c_inv = 0; m_over = 0;
            end else if (mode == 1) begin
                if (manche == 2'd0) c_inv++;
                else if (manche == 2'd1) c_p1++;
                else if (manche == 2'd2) c_p2++;
                else c_tie++;
                if (partita != 2'd0) begin
                    mode = 2; m_over = 1;
                    if (partita == 2'd1) n_p1++;
                    else if (partita == 2'd2) n_p2++;
                    else n_dr++;
                    r = '{w: int'(partita), a: c_p1, b: c_p2};
                    do_push = 1;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < 4) q.push_back(r);
                else m_ovf = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("p1_score",   32'(p1_score),   sat(c_p1, 15));
        chk("p2_score",   32'(p2_score),   sat(c_p2, 15));
        chk("ties",       32'(ties),       sat(c_tie, 15));
        chk("invalids",   32'(invalids),   sat(c_inv, 15));
        chk("games_p1",   32'(games_p1),   sat(n_p1, 255));
        chk("games_p2",   32'(games_p2),   sat(n_p2, 255));
        chk("games_draw", 32'(games_draw), sat(n_dr, 255));
        chk("game_over",  32'(game_over),  32'(m_over));
        chk("ovf",        32'(ovf),        32'(m_ovf));
        chk("res_valid",  32'(res_valid),  32'(q.size() > 0));
        chk("res_data",   32'(res_data),   (q.size() > 0) ? rec_bits(q[0], 4) : 32'd0);
        chk("w2_p1",      32'(s_p1),       sat(c_p1, 3));
        chk("w2_p2",      32'(s_p2),       sat(c_p2, 3));
        chk("w2_ties",    32'(s_ties),     sat(c_tie, 3));
        chk("w2_inv",     32'(s_inv),      sat(c_inv, 3));
        chk("w2_games",   32'({s_g1, s_g2, s_gd}), (sat(n_p1, 255) << 16) | (sat(n_p2, 255) << 8) | sat(n_dr, 255));
        chk("w2_flags",   32'({s_over, s_ovf, s_valid}), (32'(m_over) << 2) | (32'(m_ovf) << 1) | 32'(q.size() > 0));
        chk("w2_data",    32'(s_data),     (q.size() > 0) ? rec_bits(q[0], 2) : 32'd0);
    end

    task automatic step(input bit ini, input logic [1:0] m, input logic [1:0] p, input bit rdy);
        inizia = ini; manche = m; partita = p; res_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_async();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_p1", 32'(p1_score), 32'd0);
        chk("async_rst_flags", 32'({game_over, res_valid, ovf}), 32'd0);
        chk("async_rst_games", 32'({games_p1, games_p2, games_draw}), 32'd0);
        @(negedge clk);
        inizia = 0; manche = 0; partita = 0; res_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: asynchronous reset mid-game, then PLAYING inputs ignored while IDLE
        step(1, 2'b00, 2'b00, 0);
        step(0, 2'b01, 2'b00, 0);
        chk("t1_pre_p1", 32'(p1_score), 32'd1);
        reset_async();
        step(0, 2'b01, 2'b01, 0);
        chk("t1_idle_p1", 32'(p1_score), 32'd0);
        chk("t1_idle_games", 32'(games_p1), 32'd0);

        // Test 2
        step(1, 2'b00, 2'b00, 0);
        step(0, 2'b10, 2'b00, 0);
        step(0, 2'b10, 2'b00, 0);
        step(0, 2'b10, 2'b00, 0);
        step(0, 2'b01, 2'b10, 0);
        chk("t2_p1", 32'(p1_score), 32'd1);
        chk("t2_p2", 32'(p2_score), 32'd3);
        chk("t2_games_p2", 32'(games_p2), 32'd1);
        chk("t2_over", 32'(game_over), 32'd1);
        chk("t2_valid", 32'(res_valid), 32'd1);
        chk("t2_data", 32'(res_data), 32'h213);

        // Test 3: ENDED ignores further results
        repeat (3) step(0, 2'b01, 2'b10, 0);
        chk("t3_p1", 32'(p1_score), 32'd1);
        chk("t3_games_p2", 32'(games_p2), 32'd1);
        step(1, 2'b00, 2'b00, 0);
        chk("t3_clear", 32'({p1_score, p2_score, ties, invalids}), 32'd0);
        chk("t3_over", 32'(game_over), 32'd0);
        chk("t3_games_p2_hold", 32'(games_p2), 32'd1);

        // Test 4: abort an unfinished game
        step(1, 2'b00, 2'b00, 0);
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b00, 2'b00, 0);
        step(0, 2'b11, 2'b00, 0);
        chk("t4_tallies", 32'({p1_score, ties, invalids}), 32'h111);
        step(1, 2'b00, 2'b00, 0);
        chk("t4_clear", 32'({p1_score, p2_score, ties, invalids}), 32'd0);
        chk("t4_games", 32'({games_p1, games_p2, games_draw}), 32'h000100);
        chk("t4_data_hold", 32'(res_data), 32'h213);

        // Test 5: overflow of a full FIFO, then push with simultaneous pop
        reset_async();
        for (int g = 0; g < 5; g++) begin
            logic [1:0] w;
            w = (g == 1) ? 2'b10 : (g == 2) ? 2'b11 : 2'b01;
            step(1, 2'b00, 2'b00, 0);
            step(0, w, w, 0);
        end
        chk("t5_ovf", 32'(ovf), 32'd1);
        chk("t5_games_p1", 32'(games_p1), 32'd3);
        chk("t5_head", 32'(res_data), 32'h110);
        step(1, 2'b00, 2'b00, 0);
        step(0, 2'b10, 2'b10, 1);
        chk("t5_head_after_pop", 32'(res_data), 32'h201);
        chk("t5_valid", 32'(res_valid), 32'd1);
        repeat (5) step(0, 2'b00, 2'b00, 1);
        chk("t5_drained", 32'(res_valid), 32'd0);

        // Test 6: saturation of the narrow instance
        step(1, 2'b00, 2'b00, 0);
        repeat (5) step(0, 2'b01, 2'b00, 0);
        chk("t6_w2_p1", 32'(s_p1), 32'd3);
        chk("t6_w2_other", 32'({s_p2, s_ties, s_inv}), 32'd0);
        chk("t6_w4_p1", 32'(p1_score), 32'd5);
        repeat (14) step(0, 2'b01, 2'b00, 0);
        chk("t6_w4_sat", 32'(p1_score), 32'd15);

        // Randomized play
        for (int i = 0; i < 1500; i++) begin
            bit         ini;
            logic [1:0] m;
            logic [1:0] p;
            bit         rdy;
            ini = ($urandom_range(0, 7) == 0);
            m   = 2'($urandom_range(0, 3));
            p   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rdy = ($urandom_range(0, 2) == 0);
            step(ini, m, p, rdy);
            if (i == 750) reset_async();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
